// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//
// Parametrised single-clock FIFO placed between the tile I/O capture logic and
// the downstream consumers. It provides programmable almost-full and
// almost-empty levels, an occupancy count, and sticky overflow and underflow
// flags. It also supports a synchronous flush and a selectable
// first-word-fall-through (FWFT) read mode.
//
// Parameters
//   DATA_W      data word width (>= 1)
//   DEPTH       number of entries, power of two (>= 2)
//   AFULL_LVL   almost_full  when count >= AFULL_LVL  (1..DEPTH)
//   AEMPTY_LVL  almost_empty when count <= AEMPTY_LVL (0..DEPTH-1)
//   FWFT        0 = registered read (latency 1), 1 = first-word-fall-through
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               synchronous clear of contents (beats wr_en/rd_en)
//   wr_en, wr_data      write request and word
//   full, almost_full   count == DEPTH, count >= AFULL_LVL
//   rd_en               read / pop request
//   rd_data, rd_valid   read word and its qualifier
//   empty, almost_empty count == 0, count <= AEMPTY_LVL
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky error flags (write while full / read while empty)
//   clr_err             clears the sticky flags; a same-cycle new event wins
// -----------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  // Storage is deliberately left out of reset; only pointers define validity.
  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W:0]   count_s;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              ovf_evt_s;
  logic              unf_evt_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [ADDR_W-1:0] raddr_s;

  // Occupancy and status flags are decoded from the registered pointers.
  always_comb begin
    count_s      = wptr_q - rptr_q;
    full_s       = (count_s == DEPTH_C);
    empty_s      = (count_s == {(ADDR_W+1){1'b0}});
    waddr_s      = wptr_q[ADDR_W-1:0];
    raddr_s      = rptr_q[ADDR_W-1:0];
  end

  // Request qualification. Full blocks a write even when a read is accepted in
  // the same cycle, and empty blocks a read even when a write is accepted.
  // During flush, requests neither take effect nor count as error events.
  always_comb begin
    wr_acc_s  = wr_en && !full_s  && !flush;
    rd_acc_s  = rd_en && !empty_s && !flush;
    ovf_evt_s = wr_en && full_s   && !flush;
    unf_evt_s = rd_en && empty_s  && !flush;
  end

  // Next-state logic for the pointers and the registered read port.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      wptr_d     = {(ADDR_W+1){1'b0}};
      rptr_d     = {(ADDR_W+1){1'b0}};
      rd_valid_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d     = rptr_q + PTR_ONE;
        rd_data_d  = mem[raddr_s];
        rd_valid_d = 1'b1;
      end else begin
        rptr_d     = rptr_q;
        rd_valid_d = 1'b0;
      end
    end
  end

  // Sticky error flags. A new event beats clr_err in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (ovf_evt_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (unf_evt_s) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= {(ADDR_W+1){1'b0}};
      rptr_q      <= {(ADDR_W+1){1'b0}};
      rd_data_q   <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port. A word written into an empty FIFO becomes visible
  // one cycle later, once wptr_q has advanced.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[waddr_s] <= wr_data;
    end
  end

  // Output mapping. In FWFT mode the head word is shown directly, and
  // rd_valid mirrors !empty. rd_data is not gated while the FIFO is empty.
  always_comb begin
    full         = full_s;
    almost_full  = (count_s >= AFULL_C);
    empty        = empty_s;
    almost_empty = (count_s <= AEMPTY_C);
    count        = count_s;
    overflow     = overflow_q;
    underflow    = underflow_q;
    if (FWFT != 0) begin
      rd_data  = mem[raddr_s];
      rd_valid = !empty_s;
    end else begin
      rd_data  = rd_data_q;
      rd_valid = rd_valid_q;
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo. The registered-read instance is checked through a
// scoreboard queue: words expected to be accepted are pushed when they are
// written, and a monitor pops and compares whenever rd_valid is seen. A second
// instance with FWFT=1 is exercised with directed checks.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst_n;

  logic       flush, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic       full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  logic       f_flush, f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data;
  logic       f_full, f_almost_full, f_empty, f_almost_empty, f_rd_valid;
  logic       f_overflow, f_underflow;
  logic [7:0] f_rd_data;
  logic [4:0] f_count;

  int         pass_cnt;
  int         total_cnt;
  int         m_count;
  logic [7:0] sb_q[$];
  logic [7:0] exp_word;

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .full(f_full), .almost_full(f_almost_full), .rd_en(f_rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; afterwards the outputs reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the registered-read instance. The small occupancy model
  // decides acceptance, and accepted writes feed the scoreboard.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic wacc;
    logic racc;
    wacc = w && (m_count < 16);
    racc = r && (m_count > 0);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    if (wacc) sb_q.push_back(d);
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("count", 32'(count), 32'(m_count));
    if (racc) chk("rd_valid_latency1", 32'(rd_valid), 32'd1);
  endtask

  // Monitor: every valid word of the registered-read instance is compared
  // with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_word = sb_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(exp_word));
      end
    end
  end

  initial begin
    pass_cnt = 0; total_cnt = 0; m_count = 0;
    rst_n = 1'b0;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = 8'h00;

    // Reset state.
    repeat (3) step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_f_rd_valid", 32'(f_rd_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill with 0x00..0x0F. almost_full rises at 12, and full rises at 16.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_almost_full", 32'(almost_full), ((i + 1) >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), ((i + 1) == 16) ? 32'd1 : 32'd0);
    end
    chk("fill_almost_empty", 32'(almost_empty), 32'd0);

    // A 17th write is rejected and sets overflow.
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count16", 32'(count), 32'd16);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // On a full FIFO, simultaneous write and read accept only the read.
    cyc(1'b1, 8'h77, 1'b1);
    chk("full_rw_count15", 32'(count), 32'd15);
    chk("full_rw_overflow", 32'(overflow), 32'd1);
    chk("full_rw_not_full", 32'(full), 32'd0);

    // Drain the remaining 15 words; the monitor checks the order.
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_almost_empty", 32'(almost_empty), (m_count <= 2) ? 32'd1 : 32'd0);
    end
    step();
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_rd_valid_low", 32'(rd_valid), 32'd0);
    chk("drained_rd_data_hold", 32'(rd_data), 32'h0F);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // Half-full steady state across a pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'h90 + 8'(i), 1'b1);
      chk("steady_count8", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    step();

    // Reading an empty FIFO sets underflow; clr_err in the same cycle loses.
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_rd_valid", 32'(rd_valid), 32'd0);
    clr_err = 1'b1; rd_en = 1'b1; step(); clr_err = 1'b0; rd_en = 1'b0;
    chk("unf_clr_loses", 32'(underflow), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("unf_cleared", 32'(underflow), 32'd0);

    // On an empty FIFO, write plus read accepts only the write.
    cyc(1'b1, 8'h3C, 1'b1);
    chk("empty_rw_count1", 32'(count), 32'd1);
    chk("empty_rw_underflow", 32'(underflow), 32'd1);
    chk("empty_rw_no_valid", 32'(rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);

    // Flush beats same-cycle requests and leaves the sticky flags alone.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb_q.delete();
    m_count = 0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_rd_data_hold", 32'(rd_data), 32'h3C);
    chk("flush_underflow_kept", 32'(underflow), 32'd1);
    chk("flush_overflow_kept", 32'(overflow), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // FWFT instance.
    f_rd_en = 1'b1; step(); f_rd_en = 1'b0;
    chk("f_unf_set", 32'(f_underflow), 32'd1);
    chk("f_empty_invalid", 32'(f_rd_valid), 32'd0);
    f_wr_en = 1'b1; f_wr_data = 8'hA5; step(); f_wr_en = 1'b0;
    chk("f_valid_no_rd_en", 32'(f_rd_valid), 32'd1);
    chk("f_data_a5", 32'(f_rd_data), 32'hA5);
    for (int i = 1; i <= 4; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'(i); step();
    end
    f_wr_en = 1'b0;
    chk("f_count5", 32'(f_count), 32'd5);
    chk("f_head_still_a5", 32'(f_rd_data), 32'hA5);
    f_rd_en = 1'b1; step(); f_rd_en = 1'b0;
    chk("f_pop_next_head", 32'(f_rd_data), 32'h01);
    chk("f_pop_count4", 32'(f_count), 32'd4);
    f_wr_en = 1'b1; f_wr_data = 8'h05; step(); f_wr_en = 1'b0;
    chk("f_count5_again", 32'(f_count), 32'd5);
    f_flush = 1'b1; step(); f_flush = 1'b0;
    chk("f_flush_count", 32'(f_count), 32'd0);
    chk("f_flush_empty", 32'(f_empty), 32'd1);
    chk("f_flush_rd_valid", 32'(f_rd_valid), 32'd0);
    chk("f_flush_underflow_kept", 32'(f_underflow), 32'd1);
    chk("f_flush_overflow_kept", 32'(f_overflow), 32'd0);

    // Asserting reset with a read pending drops rd_valid at once.
    cyc(1'b1, 8'h44, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_count = 0;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_f_underflow", 32'(f_underflow), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    step();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
